// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction memory address/data plus the decode
// valid/ready handshake, redirect input and status flags.
interface instruction_fetch_if #(
    parameter int data_length = 32,
    parameter int AW          = 6
);
    logic [AW-1:0]          imem_addr;
    logic [data_length-1:0] imem_rdata;
    logic                   dec_ready;
    logic                   if_valid;
    logic [data_length-1:0] if_instr;
    logic [AW-1:0]          if_pc;
    logic                   redirect;
    logic [AW-1:0]          redirect_addr;
    logic                   halted;
    logic                   pc_wrap;

    // Fetch stage side.
    modport master (
        output imem_addr, if_valid, if_instr, if_pc, halted, pc_wrap,
        input  imem_rdata, dec_ready, redirect, redirect_addr
    );

    // Memory/decoder side.
    modport slave (
        input  imem_addr, if_valid, if_instr, if_pc, halted, pc_wrap,
        output imem_rdata, dec_ready, redirect, redirect_addr
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and holds
// the fetched word in an instruction register until decode accepts it.
// Supports back-pressure, branch redirect and a HALT opcode that stops fetch.
module instruction_fetch #(
    parameter  int data_length = 32,
    parameter  int mem_length  = 64,
    parameter  int START_ADDR  = 1,
    localparam int AW          = $clog2(mem_length)
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus
);

    localparam logic [4:0] HALT_OP = 5'b11111;

    typedef enum logic [1:0] {
        PRIME,
        FETCH,
        HALTWAIT,
        HALTED
    } state_e;

    state_e                 state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [AW-1:0]          if_pc_q, if_pc_d;
    logic [data_length-1:0] if_instr_q, if_instr_d;
    logic                   if_valid_q, if_valid_d;
    logic                   halted_q, halted_d;
    logic                   pc_wrap_q, pc_wrap_d;

    logic accept;
    logic advance;
    logic is_halt;
    logic pc_at_end;

    assign accept    = if_valid_q & bus.dec_ready;
    // The holding slot is either empty or being emptied this cycle.
    assign advance   = !if_valid_q | accept;
    assign is_halt   = (bus.imem_rdata[data_length-1 -: 5] == HALT_OP);
    assign pc_at_end = (pc_q == AW'(mem_length - 1));

    // Next-state logic for the fetch FSM and its datapath registers.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if_valid_d = if_valid_q;
        halted_d   = halted_q;
        pc_wrap_d  = 1'b0;

        case (state_q)
            PRIME: begin
                // Forces an address change so memory read data re-evaluates.
                pc_d    = AW'(START_ADDR);
                state_d = FETCH;
            end
            FETCH: begin
                if (advance) begin
                    if_instr_d = bus.imem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    if (is_halt) begin
                        // PC stays on the HALT word's address.
                        state_d = HALTWAIT;
                    end else begin
                        pc_d      = pc_at_end ? '0 : pc_q + AW'(1);
                        pc_wrap_d = pc_at_end;
                    end
                end
            end
            HALTWAIT: begin
                if (accept) begin
                    if_valid_d = 1'b0;
                    halted_d   = 1'b1;
                    state_d    = HALTED;
                end
            end
            HALTED: begin
                // Fetch stopped; everything holds until a redirect.
            end
            default: state_d = PRIME;
        endcase

        // Redirect overrides everything except the post-reset prime cycle,
        // dropping the held word even if it is accepted this same cycle.
        if (bus.redirect && (state_q != PRIME)) begin
            pc_d       = bus.redirect_addr;
            if_valid_d = 1'b0;
            halted_d   = 1'b0;
            pc_wrap_d  = 1'b0;
            state_d    = FETCH;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PRIME;
            pc_q       <= '0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            pc_wrap_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so all registers update from pre-edge values.
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
            pc_wrap_q  <= pc_wrap_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.halted    = halted_q;
    assign bus.pc_wrap   = pc_wrap_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch: start-up sequence,
// stall, redirect, HALT, PC wrap (8-deep instance) and async reset.
module tb_instruction_fetch;

    logic clk;
    logic rst;
    logic rst8;

    int n_checks = 0;
    int n_pass   = 0;

    instruction_fetch_if #(.data_length(32), .AW(6)) bus ();
    instruction_fetch_if #(.data_length(32), .AW(3)) bus8 ();

    logic [31:0] imem  [64];
    logic [31:0] imem8 [8];

    assign bus.imem_rdata  = imem[bus.imem_addr];
    assign bus8.imem_rdata = imem8[bus8.imem_addr];

    assign bus8.dec_ready     = 1'b1;
    assign bus8.redirect      = 1'b0;
    assign bus8.redirect_addr = '0;

    instruction_fetch #(.data_length(32), .mem_length(64), .START_ADDR(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    instruction_fetch #(.data_length(32), .mem_length(8), .START_ADDR(1)) dut8 (
        .clk (clk),
        .rst (rst8),
        .bus (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one clock and land 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string pfx);
        check({pfx, "_addr"},   32'(bus.imem_addr), 32'd0);
        check({pfx, "_valid"},  32'(bus.if_valid),  32'd0);
        check({pfx, "_instr"},  bus.if_instr,       32'd0);
        check({pfx, "_pc"},     32'(bus.if_pc),     32'd0);
        check({pfx, "_halted"}, 32'(bus.halted),    32'd0);
        check({pfx, "_wrap"},   32'(bus.pc_wrap),   32'd0);
    endtask

    // Called right after reset release (one unit past an edge), dec_ready=1.
    task automatic startup_sequence(input string pfx);
        check({pfx, "_addr0"}, 32'(bus.imem_addr), 32'd0);
        tick();
        check({pfx, "_prime_addr"},  32'(bus.imem_addr), 32'd1);
        check({pfx, "_prime_valid"}, 32'(bus.if_valid),  32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check({pfx, "_valid"}, 32'(bus.if_valid),  32'd1);
            check({pfx, "_instr"}, bus.if_instr,       32'h1000_0000 | 32'(k));
            check({pfx, "_pc"},    32'(bus.if_pc),     32'(k));
            check({pfx, "_addr"},  32'(bus.imem_addr), 32'(k + 1));
        end
    endtask

    initial begin
        rst               = 1'b1;
        rst8              = 1'b1;
        bus.dec_ready     = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        for (int i = 0; i < 64; i++) imem[i] = 32'h1000_0000 | 32'(i);
        imem[0] = 32'hDEAD_0000;
        imem[6] = 32'hF800_0000;
        for (int i = 0; i < 8; i++) imem8[i] = 32'h0800_0000 | 32'(i);

        repeat (2) tick();
        check_reset_values("rst");

        // T1: start-up sequence
        rst = 1'b0;
        startup_sequence("t1");

        // T2: stall while word 4 is held
        tick();
        check("t2_pre_pc",   32'(bus.if_pc),     32'd4);
        check("t2_pre_addr", 32'(bus.imem_addr), 32'd5);
        bus.dec_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t2_hold_valid", 32'(bus.if_valid),  32'd1);
            check("t2_hold_pc",    32'(bus.if_pc),     32'd4);
            check("t2_hold_instr", bus.if_instr,       32'h1000_0004);
            check("t2_hold_addr",  32'(bus.imem_addr), 32'd5);
        end
        bus.dec_ready = 1'b1;
        tick();
        check("t2_rel_pc",    32'(bus.if_pc),     32'd5);
        check("t2_rel_instr", bus.if_instr,       32'h1000_0005);
        check("t2_rel_addr",  32'(bus.imem_addr), 32'd6);

        // T3: redirect while valid & !ready
        bus.dec_ready     = 1'b0;
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd9;
        tick();
        check("t3_flush_valid", 32'(bus.if_valid),  32'd0);
        check("t3_flush_addr",  32'(bus.imem_addr), 32'd9);
        bus.redirect  = 1'b0;
        bus.dec_ready = 1'b1;
        tick();
        check("t3_first_valid", 32'(bus.if_valid),  32'd1);
        check("t3_first_pc",    32'(bus.if_pc),     32'd9);
        check("t3_first_instr", bus.if_instr,       32'h1000_0009);
        check("t3_first_addr",  32'(bus.imem_addr), 32'd10);

        // T3: redirect in the same cycle the HALT word would be captured
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd6;
        tick();
        check("t3h_addr6", 32'(bus.imem_addr), 32'd6);
        bus.redirect_addr = 6'd2;
        tick();
        check("t3h_halted", 32'(bus.halted),    32'd0);
        check("t3h_valid",  32'(bus.if_valid),  32'd0);
        check("t3h_addr",   32'(bus.imem_addr), 32'd2);
        bus.redirect = 1'b0;
        tick();
        check("t3h_pc2",   32'(bus.if_pc),     32'd2);
        check("t3h_addr3", 32'(bus.imem_addr), 32'd3);
        tick();
        check("t3h_pc3", 32'(bus.if_pc), 32'd3);

        // T4: run into HALT at address 6
        repeat (2) tick();
        check("t4_pc5", 32'(bus.if_pc), 32'd5);
        tick();
        check("t4_halt_pc",     32'(bus.if_pc),     32'd6);
        check("t4_halt_instr",  bus.if_instr,       32'hF800_0000);
        check("t4_halt_valid",  32'(bus.if_valid),  32'd1);
        check("t4_halt_addr",   32'(bus.imem_addr), 32'd6);
        check("t4_halt_flag0",  32'(bus.halted),    32'd0);
        bus.dec_ready = 1'b0;
        tick();
        check("t4_wait_valid",  32'(bus.if_valid),  32'd1);
        check("t4_wait_halted", 32'(bus.halted),    32'd0);
        check("t4_wait_addr",   32'(bus.imem_addr), 32'd6);
        bus.dec_ready = 1'b1;
        tick();
        check("t4_acc_valid",  32'(bus.if_valid),  32'd0);
        check("t4_acc_halted", 32'(bus.halted),    32'd1);
        check("t4_acc_addr",   32'(bus.imem_addr), 32'd6);
        tick();
        check("t4_frozen_halted", 32'(bus.halted),    32'd1);
        check("t4_frozen_addr",   32'(bus.imem_addr), 32'd6);
        check("t4_frozen_valid",  32'(bus.if_valid),  32'd0);
        bus.redirect      = 1'b1;
        bus.redirect_addr = 6'd1;
        tick();
        check("t4_resume_halted", 32'(bus.halted),    32'd0);
        check("t4_resume_addr",   32'(bus.imem_addr), 32'd1);
        bus.redirect = 1'b0;
        tick();
        check("t4_resume_pc",    32'(bus.if_pc), 32'd1);
        check("t4_resume_instr", bus.if_instr,   32'h1000_0001);

        // T6: asynchronous reset mid-stall
        bus.dec_ready = 1'b0;
        repeat (2) tick();
        check("t6_stall_valid", 32'(bus.if_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("t6_async");
        bus.dec_ready = 1'b1;
        tick();
        rst = 1'b0;
        startup_sequence("t6");

        // T5: 8-deep instance free-runs and wraps
        rst8 = 1'b0;
        check("t5_addr0", 32'(bus8.imem_addr), 32'd0);
        tick();
        check("t5_addr1", 32'(bus8.imem_addr), 32'd1);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("t5_pc",   32'(bus8.if_pc),   32'(k));
            check("t5_wrap", 32'(bus8.pc_wrap), (k == 7) ? 32'd1 : 32'd0);
        end
        tick();
        check("t5_after_pc",    32'(bus8.if_pc),   32'd0);
        check("t5_after_wrap",  32'(bus8.pc_wrap), 32'd0);
        check("t5_after_instr", bus8.if_instr,     32'h0800_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
